pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//   Program-counter and fetch-control stage at the front of the pipeline.
//   Holds the fetch PC, advances it by 4, applies stalls from the hazard unit
//   and redirects from branch/jump resolution. Drives the load and flush
//   controls of the IF/ID pipeline register directly downstream.
//   Runs a small boot/run/halt state machine so that no fetch is issued before
//   the boot delay, and none after a misaligned redirect.
// PARAMETERS
//   N           32   PC / address width in bits (N >= 4)
//   RESET_PC    0    PC value loaded on reset; must be word aligned
//   BOOT_CYCLES 2    idle cycles after reset release before first fetch (>=1)
// PORTS
//   clk              in   1   clock, all state updates on rising edge
//   rst              in   1   synchronous reset, active low
//   stall            in   1   hazard unit: hold PC and IF/ID contents
//   redirect         in   1   branch taken / jump resolved this cycle
//   redirect_target  in   N   new fetch address, valid while redirect=1
//   pc               out  N   current fetch address to instruction memory
//   pc_plus4         out  N   pc+4 (mod 2^N), forwarded into IF/ID for link
//   if_id_load       out  1   load enable for the IF/ID register
//   if_id_flush      out  1   squash IF/ID contents (insert bubble)
//   fetch_valid      out  1   1 when the instruction at pc is architectural
//   misalign         out  1   sticky: redirect_target[1:0] != 0 was seen
// BEHAVIOUR
//   - rst==0 at a rising edge:
//     pc=RESET_PC, state=BOOT, boot_cnt=0, misalign=0.
//     Applies regardless of state; reset mid-operation discards all state.
//   - Outputs are decoded from state and inputs (no extra latency):
//     BOOT: if_id_load=0, if_id_flush=1, fetch_valid=0; pc held.
//     RUN : fetch_valid=1; if_id_flush=redirect;
//           if_id_load = ~stall & ~redirect.
//     HALT: if_id_load=0, if_id_flush=1, fetch_valid=0, misalign=1; pc held.
//   - BOOT: boot_cnt increments each cycle.
//     -> RUN at the edge where boot_cnt==BOOT_CYCLES-1.
//     stall and redirect are ignored in BOOT.
//   - RUN, priority redirect > stall > advance:
//     redirect=1, target[1:0]==0 : pc<=redirect_target, stay RUN.
//     redirect=1, target[1:0]!=0 : pc held, misalign<=1, -> HALT.
//     stall=1 (no redirect)      : pc held.
//     otherwise                  : pc<=pc+4.
//   - Redirect with stall in the same cycle: redirect wins, the wrong-path
//     instruction is flushed, and stall is not honoured for that cycle.
//   - Arithmetic: pc+4 is N-bit unsigned with wrap-around; no overflow flag.
//   - HALT is left only via reset.
//   - pc_plus4 is combinational from pc in all states.
// TESTING
//   1. rst=0 for 1 cycle, then rst=1 (BOOT_CYCLES=2)
//      -> pc=0, load=0, flush=1 for 2 cycles; then pc 0,4,8, load=1.
//   2. In RUN at pc=0x10, stall=1 for 3 cycles
//      -> pc stays 0x10, load=0; next cycle pc=0x14.
//   3. pc=0x20, redirect=1, target=0x100, stall=1
//      -> flush=1, load=0 that cycle; next pc=0x100, load=1.
//   4. RESET_PC=0xFFFFFFFC, run 2 cycles past BOOT
//      -> pc=0xFFFFFFFC, then 0x00000000; pc_plus4 wraps likewise.
//   5. redirect=1, target=0x102
//      -> misalign=1, HALT; pc and outputs frozen for 10+ cycles until rst=0.
//   6. rst=0 at pc=0x40 mid-run with redirect=1
//      -> next edge pc=RESET_PC, BOOT; misalign cleared; redirect ignored.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program-counter / fetch-control stage.
// Holds the fetch PC, steps it by 4, honours hazard stalls and branch/jump
// redirects, and drives the IF/ID load/flush controls. A BOOT/RUN/HALT
// state machine keeps fetch idle for BOOT_CYCLES after reset and stops it
// permanently (until reset) after a misaligned redirect target.
module pc_fetch_unit #(
    parameter int           N           = 32,
    parameter logic [N-1:0] RESET_PC    = '0,
    parameter int           BOOT_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         redirect,
    input  logic [N-1:0] redirect_target,
    output logic [N-1:0] pc,
    output logic [N-1:0] pc_plus4,
    output logic         if_id_load,
    output logic         if_id_flush,
    output logic         fetch_valid,
    output logic         misalign
);

    // Counter only needs to reach BOOT_CYCLES-1; keep at least one bit.
    localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [N-1:0]     pc_q, pc_nxt;
    logic [CNT_W-1:0] boot_cnt, boot_cnt_nxt;
    logic             mis_q, mis_nxt;

    // Sequential PC increment; wraps modulo 2^N with no overflow indication.
    function automatic logic [N-1:0] incr4(input logic [N-1:0] a);
        return a + N'(4);
    endfunction

    // State, PC, boot counter and sticky misalign flag; reset discards everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= BOOT;
            pc_q     <= RESET_PC;
            boot_cnt <= '0;
            mis_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc_q     <= pc_nxt;
            boot_cnt <= boot_cnt_nxt;
            mis_q    <= mis_nxt;
        end
    end

    // Next-state and IF/ID control decode; redirect outranks stall in RUN.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc_q;
        boot_cnt_nxt = boot_cnt;
        mis_nxt      = mis_q;
        if_id_load   = 1'b0;
        if_id_flush  = 1'b1;
        fetch_valid  = 1'b0;
        case (state)
            BOOT: begin
                // stall/redirect deliberately ignored until the boot delay ends
                if (boot_cnt == BOOT_LAST) begin
                    state_nxt    = RUN;
                    boot_cnt_nxt = '0;
                end else begin
                    boot_cnt_nxt = boot_cnt + CNT_W'(1);
                end
            end
            RUN: begin
                fetch_valid = 1'b1;
                if_id_flush = redirect;
                if_id_load  = ~stall & ~redirect;
                if (redirect) begin
                    if (redirect_target[1:0] == 2'b00) begin
                        pc_nxt = redirect_target;
                    end else begin
                        // PC is held so the faulting fetch address stays visible
                        mis_nxt   = 1'b1;
                        state_nxt = HALT;
                    end
                end else if (!stall) begin
                    pc_nxt = incr4(pc_q);
                end
            end
            HALT: begin
                // Terminal until reset: outputs keep their idle defaults
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    assign pc       = pc_q;
    assign pc_plus4 = incr4(pc_q);
    assign misalign = mis_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a vector table for the main
// sequence plus a hand-written mid-run reset sequence. A second instance
// with RESET_PC=0xFFFFFFFC shares the stimulus to exercise PC wrap-around.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, stall, redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc, pc_plus4, pc2, pc_plus4_2;
    logic        if_id_load, if_id_flush, fetch_valid, misalign;
    logic        load2, flush2, valid2, mis2;

    pc_fetch_unit #(.N(32), .RESET_PC(32'h0), .BOOT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .pc(pc), .pc_plus4(pc_plus4),
        .if_id_load(if_id_load), .if_id_flush(if_id_flush),
        .fetch_valid(fetch_valid), .misalign(misalign)
    );

    pc_fetch_unit #(.N(32), .RESET_PC(32'hFFFF_FFFC), .BOOT_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_target(redirect_target), .pc(pc2), .pc_plus4(pc_plus4_2),
        .if_id_load(load2), .if_id_flush(flush2),
        .fetch_valid(valid2), .misalign(mis2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, stall, redir;
        logic [31:0] tgt;
        logic        chk;
        logic [31:0] pc;
        logic        load, flush, valid, mis;
        logic        chk2;
        logic [31:0] pc2;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic        load, flush, valid, mis;
        logic        chk2;
        logic [31:0] pc2;
    } exp_t;

    exp_t sb[$];
    int   total  = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Drive one cycle of inputs at the falling edge, queue the expected
    // outputs, then compare them while the inputs are still applied.
    task automatic apply(input vec_t v);
        exp_t e, g;
        @(negedge clk);
        rst             = v.rst;
        stall           = v.stall;
        redirect        = v.redir;
        redirect_target = v.tgt;
        if (v.chk) begin
            e.pc = v.pc; e.load = v.load; e.flush = v.flush; e.valid = v.valid;
            e.mis = v.mis; e.chk2 = v.chk2; e.pc2 = v.pc2;
            sb.push_back(e);
        end
        #1;
        if (v.chk) begin
            if (sb.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                g = sb.pop_front();
                check("pc",          pc,                    g.pc);
                check("pc_plus4",    pc_plus4,              g.pc + 32'd4);
                check("if_id_load",  {31'd0, if_id_load},   {31'd0, g.load});
                check("if_id_flush", {31'd0, if_id_flush},  {31'd0, g.flush});
                check("fetch_valid", {31'd0, fetch_valid},  {31'd0, g.valid});
                check("misalign",    {31'd0, misalign},     {31'd0, g.mis});
                if (g.chk2) begin
                    check("wrap_pc",       pc2,        g.pc2);
                    check("wrap_pc_plus4", pc_plus4_2, g.pc2 + 32'd4);
                end
            end
        end
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic rd,
                                input logic [31:0] t, input logic c,
                                input logic [31:0] p, input logic ld,
                                input logic fl, input logic va, input logic mi);
        vec_t v;
        v.rst = r; v.stall = s; v.redir = rd; v.tgt = t; v.chk = c;
        v.pc = p; v.load = ld; v.flush = fl; v.valid = va; v.mis = mi;
        v.chk2 = 1'b0; v.pc2 = '0;
        return v;
    endfunction

    vec_t tbl[$];
    vec_t v;

    initial begin
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0;

        // Reset, then two BOOT cycles, then sequential fetch
        tbl.push_back(mk(0,0,0,32'h0,   0, 32'h0,   0,1,0,0));
        v = mk(1,0,0,32'h0,0,32'h0,0,1,0,0); v.chk = 1; v.chk2 = 1; v.pc2 = 32'hFFFF_FFFC; tbl.push_back(v);
        v = mk(1,0,0,32'h0,1,32'h0,0,1,0,0);            v.chk2 = 1; v.pc2 = 32'hFFFF_FFFC; tbl.push_back(v);
        v = mk(1,0,0,32'h0,1,32'h0,1,0,1,0);            v.chk2 = 1; v.pc2 = 32'hFFFF_FFFC; tbl.push_back(v);
        v = mk(1,0,0,32'h0,1,32'h4,1,0,1,0);            v.chk2 = 1; v.pc2 = 32'h0;         tbl.push_back(v);
        v = mk(1,0,0,32'h0,1,32'h8,1,0,1,0);            v.chk2 = 1; v.pc2 = 32'h4;         tbl.push_back(v);
        tbl.push_back(mk(1,0,0,32'h0,   1, 32'hC,   1,0,1,0));
        // Stall three cycles at 0x10, then advance
        tbl.push_back(mk(1,1,0,32'h0,   1, 32'h10,  0,0,1,0));
        tbl.push_back(mk(1,1,0,32'h0,   1, 32'h10,  0,0,1,0));
        tbl.push_back(mk(1,1,0,32'h0,   1, 32'h10,  0,0,1,0));
        tbl.push_back(mk(1,0,0,32'h0,   1, 32'h10,  1,0,1,0));
        tbl.push_back(mk(1,0,0,32'h0,   1, 32'h14,  1,0,1,0));
        tbl.push_back(mk(1,0,0,32'h0,   1, 32'h18,  1,0,1,0));
        tbl.push_back(mk(1,0,0,32'h0,   1, 32'h1C,  1,0,1,0));
        // Redirect with simultaneous stall: redirect wins
        tbl.push_back(mk(1,1,1,32'h100, 1, 32'h20,  0,1,1,0));
        tbl.push_back(mk(1,0,0,32'h0,   1, 32'h100, 1,0,1,0));
        // Misaligned redirect: HALT, frozen despite further inputs
        tbl.push_back(mk(1,0,1,32'h102, 1, 32'h104, 0,1,1,0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(1, i[0], i[1], 32'h200, 1, 32'h104, 0,1,0,1));

        foreach (tbl[i]) apply(tbl[i]);

        // Reset out of HALT, boot, run up to 0x3C
        apply(mk(0,0,0,32'h0, 1, 32'h104, 0,1,0,1));
        apply(mk(1,0,0,32'h0, 1, 32'h0,   0,1,0,0));
        apply(mk(1,0,0,32'h0, 1, 32'h0,   0,1,0,0));
        for (int k = 0; k < 16; k++)
            apply(mk(1,0,0,32'h0, 1, 32'(k*4), 1,0,1,0));
        // Reset at 0x40 with a redirect pending: reset wins, redirect ignored in BOOT
        apply(mk(0,0,1,32'h80, 1, 32'h40, 0,1,1,0));
        apply(mk(1,0,1,32'h80, 1, 32'h0,  0,1,0,0));
        apply(mk(1,1,1,32'h80, 1, 32'h0,  0,1,0,0));
        apply(mk(1,0,0,32'h0,  1, 32'h0,  1,0,1,0));
        apply(mk(1,0,0,32'h0,  1, 32'h4,  1,0,1,0));

        if (sb.size() != 0) check("scoreboard_leftover", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
